// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed 7-segment display controller.
// Sequential double-dabble BCD conversion feeding a guarded digit scan.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous, active-low reset
//   en        1 = display on; 0 = blank outputs, scan frozen
//   load      one-cycle strobe capturing value_in (ignored while busy)
//   value_in  binary value 0..9999, larger values saturate to 9999
//   busy      conversion in progress
//   ovf       displayed value was saturated
//   seg       segments, active high, [6:0]=g..a, [7]=dp
//   dig_n     digit enables, active-low one-hot, bit0 = units
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 3000,
    parameter int GUARD    = 16,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [13:0] value_in,
    output logic        busy,
    output logic        ovf,
    output logic [7:0]  seg,
    output logic [3:0]  dig_n
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    state_t      state;
    logic [13:0] bin;
    logic [15:0] work;
    logic [15:0] adj;
    logic [15:0] bcd;
    logic [3:0]  iter;
    logic        ovf_pend;

    logic [DW-1:0] div;
    logic [1:0]    idx;
    logic          div_tc;
    logic          in_guard;
    logic [3:0]    digit;
    logic [3:0]    lz;
    logic [7:0]    seg_nxt;

    // Add-3 correction on every BCD nibble ahead of the shift.
    always_comb begin
        adj = work;
        for (int i = 0; i < 4; i++) begin
            if (work[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bin      <= '0;
            work     <= '0;
            iter     <= '0;
            ovf_pend <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        if (value_in > 14'd9999) begin
                            bin      <= 14'd9999;
                            ovf_pend <= 1'b1;
                        end else begin
                            bin      <= value_in;
                            ovf_pend <= 1'b0;
                        end
                        work  <= '0;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    work <= {adj[14:0], bin[13]};
                    bin  <= {bin[12:0], 1'b0};
                    iter <= iter + 4'd1;
                    if (iter == 4'd13) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    // Value and overflow flag change together.
                    bcd   <= work;
                    ovf   <= ovf_pend;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign div_tc   = (div == DW'(SCAN_DIV - 1));
    assign in_guard = (div < DW'(GUARD));
    assign digit    = bcd[{idx, 2'b00} +: 4];

    // lz[k]: digits k..3 are all zero; units never blanks.
    assign lz[3] = (bcd[15:12] == 4'd0);
    assign lz[2] = lz[3] && (bcd[11:8] == 4'd0);
    assign lz[1] = lz[2] && (bcd[7:4] == 4'd0);
    assign lz[0] = 1'b0;

    always_comb begin
        case (digit)
            4'd0:    seg_nxt = 8'h3f;
            4'd1:    seg_nxt = 8'h06;
            4'd2:    seg_nxt = 8'h5b;
            4'd3:    seg_nxt = 8'h4f;
            4'd4:    seg_nxt = 8'h66;
            4'd5:    seg_nxt = 8'h6d;
            4'd6:    seg_nxt = 8'h7d;
            4'd7:    seg_nxt = 8'h07;
            4'd8:    seg_nxt = 8'h7f;
            4'd9:    seg_nxt = 8'h6f;
            default: seg_nxt = 8'h00;
        endcase
        if (BLANK_LZ && lz[idx]) begin
            seg_nxt = 8'h00;
        end
        seg_nxt[7] = ovf && (idx == 2'd3);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div   <= '0;
            idx   <= '0;
            seg   <= 8'h00;
            dig_n <= 4'hF;
        end else if (!en) begin
            seg   <= 8'h00;
            dig_n <= 4'hF;
        end else begin
            if (div_tc) begin
                div <= '0;
                idx <= idx + 2'd1;
            end else begin
                div <= div + DW'(1);
            end
            // All digits off at slot start to suppress ghosting.
            if (in_guard) begin
                seg   <= 8'h00;
                dig_n <= 4'hF;
            end else begin
                seg   <= seg_nxt;
                dig_n <= ~(4'b0001 << idx);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl.
// Two instances share stimulus: leading-zero blanking on and off.
module tb_seg_scan_ctrl;

    localparam int SD = 8;
    localparam int GD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [13:0] value_in = '0;
    logic        busy, ovf, busy0, ovf0;
    logic [7:0]  seg, seg0;
    logic [3:0]  dig_n, dig_n0;

    seg_scan_ctrl #(.SCAN_DIV(SD), .GUARD(GD), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .value_in(value_in), .busy(busy), .ovf(ovf),
        .seg(seg), .dig_n(dig_n)
    );

    seg_scan_ctrl #(.SCAN_DIV(SD), .GUARD(GD), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .value_in(value_in), .busy(busy0), .ovf(ovf0),
        .seg(seg0), .dig_n(dig_n0)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        bit o;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cur_val = 0;
    bit   cur_ovf = 1'b0;
    int   cyc = 0;
    int   last_acc = -100;
    int   ticks = 0;
    int   pos_q = 0;
    bit   en_q = 1'b0;
    int   lut[10] = '{'h3f, 'h06, 'h5b, 'h4f, 'h66,
                      'h6d, 'h7d, 'h07, 'h7f, 'h6f};

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t",
                      name, act, exp, $time);
    endfunction

    // Expected segments for digit k of value v.
    function automatic int exp_seg(int v, bit o, int k, bit blz);
        int p;
        int d;
        int s;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        d = (v / p) % 10;
        s = lut[d];
        if (blz && k > 0 && v < p) s = 0;
        if (o && k == 3) s = s | 'h80;
        return s;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Count enabled edges since reset: slot position of the scan.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ticks <= 0;
            pos_q <= 0;
            en_q  <= 1'b0;
        end else begin
            en_q  <= en;
            pos_q <= ticks;
            if (en) ticks <= ticks + 1;
        end
    end

    bit prev_busy = 1'b0;
    int bcnt = 0;

    always @(negedge clk) begin
        int k;
        int w;
        int ed;
        exp_t e;
        if (!rst) begin
            prev_busy = 1'b0;
            bcnt = 0;
        end else begin
            w = pos_q % SD;
            k = (pos_q / SD) % 4;
            if (!en_q || w < GD) begin
                chk("blank", int'({dig_n, seg}), 'hF00);
                chk("blank0", int'({dig_n0, seg0}), 'hF00);
            end else begin
                ed = (~(1 << k)) & 'hF;
                chk("dig_n", int'(dig_n), ed);
                chk("seg", int'(seg), exp_seg(cur_val, cur_ovf, k, 1'b1));
                chk("dig_n0", int'(dig_n0), ed);
                chk("seg0", int'(seg0), exp_seg(cur_val, cur_ovf, k, 1'b0));
            end
            if (busy) bcnt++;
            if (prev_busy && !busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_commit", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("busy_len", bcnt, 15);
                    chk("ovf", int'(ovf), int'(e.o));
                    chk("ovf0", int'(ovf0), int'(e.o));
                    cur_val = e.val;
                    cur_ovf = e.o;
                end
                bcnt = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; the load is sampled at the next edge.
    task automatic do_load(int v);
        int e;
        exp_t x;
        e = cyc + 1;
        if (e >= last_acc + 16) begin
            x.val = (v > 9999) ? 9999 : v;
            x.o = (v > 9999);
            sb.push_back(x);
            last_acc = e;
        end
        load = 1'b1;
        value_in = 14'(v);
        step(1);
        load = 1'b0;
    endtask

    task automatic hit_reset();
        rst = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_dig_n", int'(dig_n), 'hF);
        chk("rst_seg", int'(seg), 0);
        sb.delete();
        cur_val = 0;
        cur_ovf = 1'b0;
        last_acc = -100;
        step(2);
        rst = 1'b1;
    endtask

    initial begin
        int v;
        #2;
        hit_reset();
        en = 1'b1;
        step(40);
        do_load(1234);
        step(50);
        do_load(10000);
        step(50);
        do_load(5);
        step(50);
        do_load(7);
        step(4);
        do_load(42);
        step(9);
        do_load(7);
        do_load(0);
        step(50);
        do_load(105);
        step(50);
        do_load(12000);
        step(50);
        do_load(9876);
        step(7);
        hit_reset();
        step(40);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                en = 1'b0;
                step($urandom_range(1, 12));
                en = 1'b1;
            end
            case ($urandom_range(0, 4))
                0: v = $urandom_range(10000, 16383);
                1: v = $urandom_range(0, 99);
                default: v = $urandom_range(0, 9999);
            endcase
            do_load(v);
            step($urandom_range(2, 50));
        end
        step(40);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
